// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package seg_pkg;

  localparam logic [3:0] CODE_ZERO  = 4'ha;
  localparam logic [3:0] CODE_BLANK = 4'hf;
  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] AN_ALL_OFF = 8'hff;

  function automatic logic [3:0] nibble_at(input logic [31:0] word, input logic [2:0] sel);
    return word[{sel, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick.sv
// Refresh divider: pulses tick once every REFRESH_DIV cycles and steps the 3-bit scan index.
module scan_tick_gen #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick,
  output logic [2:0] idx
);

  localparam int            CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;

  // counter wrap and index advance
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (tick) begin
      cnt_d = {CW{1'b0}};
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
      idx_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed scan controller with double-buffered, frame-aligned display loads.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 8,
  parameter int LZ_BLANK    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        load_ack,
  input  logic [7:0]  en_mask,
  output logic [7:0]  an,
  output logic [3:0]  digit_code
);

  import seg_pkg::*;

  logic        tick;
  logic [2:0]  idx;
  logic        frame_end;
  logic [31:0] pending_q, pending_d;
  logic [31:0] display_q, display_d;
  logic        pending_full_q, pending_full_d;
  logic        load_ack_q, load_ack_d;
  logic [7:0]  an_q, an_d;
  logic [3:0]  code_q, code_d;
  logic [7:0]  lead_zero;
  logic [3:0]  nib;
  logic        dark;

  scan_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .idx   (idx)
  );

  // load handshake into the pending buffer and commit at frame boundaries
  always_comb begin
    frame_end      = tick && (idx == 3'd7);
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    display_d      = display_q;
    load_ack_d     = 1'b0;
    if (data_valid && !pending_full_q) begin
      pending_d      = data;
      pending_full_d = 1'b1;
    end else if (frame_end && pending_full_q) begin
      display_d      = pending_q;
      pending_full_d = 1'b0;
      load_ack_d     = 1'b1;
    end else begin
      pending_full_d = pending_full_q;
    end
  end

  // digit mapping; lead_zero[i] means digits 7..i are all zero
  always_comb begin
    lead_zero = 8'h00;
    lead_zero[NUM_DIGITS-1] = (display_q[31:28] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (nibble_at(display_q, 3'(i)) == 4'h0);
    end
    nib  = nibble_at(display_q, idx);
    dark = !en_mask[idx] || (nib > 4'd9) ||
           ((LZ_BLANK != 0) && (idx != 3'd0) && lead_zero[idx]);
    if (dark) begin
      an_d   = AN_ALL_OFF;
      code_d = CODE_BLANK;
    end else begin
      an_d   = ~(8'b0000_0001 << idx);
      code_d = (nib == 4'h0) ? CODE_ZERO : nib;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= 32'h0000_0000;
      display_q      <= 32'h0000_0000;
      pending_full_q <= 1'b0;
      load_ack_q     <= 1'b0;
      an_q           <= AN_ALL_OFF;
      code_q         <= CODE_BLANK;
    end else begin
      pending_q      <= pending_d;
      display_q      <= display_d;
      pending_full_q <= pending_full_d;
      load_ack_q     <= load_ack_d;
      an_q           <= an_d;
      code_q         <= code_d;
    end
  end

  assign data_ready = ~pending_full_q;
  assign load_ack   = load_ack_q;
  assign an         = an_q;
  assign digit_code = code_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed frame scenarios plus randomized loads against a slot-level model.
module tb_seg_scan_ctrl;

  localparam int DIV = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic        data_valid;
  logic [7:0]  en_mask;
  logic        data_ready, load_ack;
  logic [7:0]  an;
  logic [3:0]  digit_code;
  logic        ready_n, ack_n;
  logic [7:0]  an_n;
  logic [3:0]  code_n;

  int checks = 0;
  int fails  = 0;

  seg_scan_ctrl #(.REFRESH_DIV(DIV), .NUM_DIGITS(8), .LZ_BLANK(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .load_ack(load_ack), .en_mask(en_mask),
    .an(an), .digit_code(digit_code)
  );

  seg_scan_ctrl #(.REFRESH_DIV(DIV), .NUM_DIGITS(8), .LZ_BLANK(0)) u_dut_nlz (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .data_ready(ready_n), .load_ack(ack_n), .en_mask(en_mask),
    .an(an_n), .digit_code(code_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int unsigned k;          // clock edges since reset release
  logic [31:0] m_disp, m_pend;
  logic        m_full, m_ack;
  logic [7:0]  m_an, m_an_n;
  logic [3:0]  m_code, m_code_n;

  function automatic logic [11:0] exp_slot(input logic [31:0] disp, input int s,
                                           input logic [7:0] mask, input bit lz);
    logic [31:0] upper;
    logic [3:0]  nibv;
    logic [7:0]  one;
    upper = disp >> (4 * s);
    nibv  = upper[3:0];
    one   = 8'd1;
    if (!mask[s] || nibv > 4'd9 || (lz && s >= 1 && upper == 32'd0))
      return {8'hff, 4'hf};
    return {~(one << s), (nibv == 4'd0) ? 4'ha : nibv};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0; m_disp <= 32'd0; m_pend <= 32'd0; m_full <= 1'b0; m_ack <= 1'b0;
      m_an <= 8'hff; m_code <= 4'hf; m_an_n <= 8'hff; m_code_n <= 4'hf;
    end else begin
      {m_an, m_code}     <= exp_slot(m_disp, int'((k / DIV) % 8), en_mask, 1'b1);
      {m_an_n, m_code_n} <= exp_slot(m_disp, int'((k / DIV) % 8), en_mask, 1'b0);
      m_ack <= ((k % (8 * DIV)) == (8 * DIV - 1)) && m_full;
      if (data_valid && !m_full) begin
        m_pend <= data; m_full <= 1'b1;
      end else if ((k % (8 * DIV)) == (8 * DIV - 1) && m_full) begin
        m_disp <= m_pend; m_full <= 1'b0;
      end
      k <= k + 1;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; data = 32'd0; data_valid = 1'b0; en_mask = 8'hff;
    repeat (3) @(negedge clk);
    checks++;
    if ({an, digit_code, data_ready, load_ack} !== {8'hff, 4'hf, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: got an=%h code=%h rdy=%b ack=%b, want ff f 1 0", an, digit_code, data_ready, load_ack);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (an !== 8'hff) begin fails++; $display("FAIL reset_release_idle: an=%h want ff", an); end
    @(negedge clk);
    checks++;
    if ({an, digit_code} !== {8'hfe, 4'ha}) begin
      fails++; $display("FAIL first_slot: an=%h code=%h want fe a", an, digit_code);
    end
    checks++;
    if ({an, digit_code, load_ack, data_ready} !== {m_an, m_code, m_ack, ~m_full}) begin
      fails++; $display("FAIL reset_model: got %h %h %b %b want %h %h %b %b", an, digit_code, load_ack, data_ready, m_an, m_code, m_ack, ~m_full);
    end
  endtask

  task automatic load_and_check_frame(input string name, input logic [31:0] d, input logic [7:0] mask,
                                      input logic [63:0] ea, input logic [31:0] ec,
                                      input logic [63:0] ea_n, input logic [31:0] ec_n);
    bit got;
    int acks;
    int s;
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (data_ready) got = 1;
    end
    checks++;
    if (!got) begin fails++; $display("FAIL %s_ready_timeout: data_ready=%b want 1", name, data_ready); end
    en_mask = mask; data = d; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    checks++;
    if (data_ready !== 1'b0) begin fails++; $display("FAIL %s_ready_after_load: got %b want 0", name, data_ready); end
    got = 0;
    for (int c = 0; c < 80 && !got; c++) begin
      @(negedge clk);
      checks++;
      if ({an, digit_code, load_ack, data_ready} !== {m_an, m_code, m_ack, ~m_full}) begin
        fails++; $display("FAIL %s_wait_model: got %h %h %b %b want %h %h %b %b", name, an, digit_code, load_ack, data_ready, m_an, m_code, m_ack, ~m_full);
      end
      if (load_ack) got = 1;
    end
    checks++;
    if (!got) begin fails++; $display("FAIL %s_ack_timeout: load_ack never seen, want 1", name); end
    acks = 0;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      s = j / 4;
      checks++;
      if ({an, digit_code} !== {ea[s*8 +: 8], ec[s*4 +: 4]}) begin
        fails++; $display("FAIL %s_slot%0d: got an=%h code=%h want an=%h code=%h", name, s, an, digit_code, ea[s*8 +: 8], ec[s*4 +: 4]);
      end
      checks++;
      if ({an_n, code_n} !== {ea_n[s*8 +: 8], ec_n[s*4 +: 4]}) begin
        fails++; $display("FAIL %s_nlz_slot%0d: got an=%h code=%h want an=%h code=%h", name, s, an_n, code_n, ea_n[s*8 +: 8], ec_n[s*4 +: 4]);
      end
      if (load_ack) acks++;
    end
    checks++;
    if (acks != 0) begin fails++; $display("FAIL %s_extra_ack: got %0d acks want 0", name, acks); end
  endtask

  task automatic test_load_1234();
    load_and_check_frame("load1234", 32'h0000_1234, 8'hff,
                         64'hff_ff_ff_ff_f7_fb_fd_fe, 32'hffff_1234,
                         64'h7f_bf_df_ef_f7_fb_fd_fe, 32'haaaa_1234);
  endtask

  task automatic test_zero();
    load_and_check_frame("zero", 32'h0000_0000, 8'hff,
                         64'hff_ff_ff_ff_ff_ff_ff_fe, 32'hffff_fffa,
                         64'h7f_bf_df_ef_f7_fb_fd_fe, 32'haaaa_aaaa);
  endtask

  task automatic test_mask();
    load_and_check_frame("mask", 32'h000c_0005, 8'hfe,
                         64'hff_ff_ff_ff_f7_fb_fd_ff, 32'hffff_aaaf,
                         64'h7f_bf_df_ff_f7_fb_fd_ff, 32'haaaf_aaaf);
    en_mask = 8'hff;
  endtask

  task automatic test_back_to_back();
    int acks;
    int since;
    logic xfer;
    data = 32'h1111_1111; data_valid = 1'b1; en_mask = 8'hff;
    for (int c = 0; c < 100 && !data_ready; c++) @(negedge clk);
    @(negedge clk);
    data = 32'h2222_2222;
    acks = 0; since = 99;
    for (int c = 0; c < 200 && !(acks == 2 && since >= 32); c++) begin
      xfer = data_valid && data_ready;
      @(negedge clk);
      if (xfer) data_valid = 1'b0;
      checks++;
      if ({an, digit_code, load_ack, data_ready} !== {m_an, m_code, m_ack, ~m_full}) begin
        fails++; $display("FAIL b2b_model: got %h %h %b %b want %h %h %b %b", an, digit_code, load_ack, data_ready, m_an, m_code, m_ack, ~m_full);
      end
      if (load_ack) begin
        acks++; since = 0;
      end else begin
        if (acks == 0) begin
          checks++;
          if (data_ready !== 1'b0) begin fails++; $display("FAIL b2b_hold: data_ready=%b want 0", data_ready); end
        end
        if (since < 32) begin
          checks++;
          if ({an, digit_code} !== {~(8'd1 << (since / 4)), 4'(acks)}) begin
            fails++; $display("FAIL b2b_frame%0d: got an=%h code=%h want an=%h code=%0d", acks, an, digit_code, ~(8'd1 << (since / 4)), acks);
          end
          since++;
        end
      end
    end
    checks++;
    if (acks != 2) begin fails++; $display("FAIL b2b_acks: got %0d want 2", acks); end
    data_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++;
      if ({an, digit_code, load_ack, data_ready} !== {m_an, m_code, m_ack, ~m_full}) begin
        fails++; $display("FAIL rand_model: got %h %h %b %b want %h %h %b %b", an, digit_code, load_ack, data_ready, m_an, m_code, m_ack, ~m_full);
      end
      checks++;
      if ({an_n, code_n, ack_n, ready_n} !== {m_an_n, m_code_n, m_ack, ~m_full}) begin
        fails++; $display("FAIL rand_nlz_model: got %h %h %b %b want %h %h %b %b", an_n, code_n, ack_n, ready_n, m_an_n, m_code_n, m_ack, ~m_full);
      end
      data       = $urandom >> (4 * $urandom_range(0, 7));
      data_valid = ($urandom_range(0, 3) == 0);
      en_mask    = ($urandom_range(0, 1) == 0) ? 8'hff : 8'($urandom);
    end
    data_valid = 1'b0; en_mask = 8'hff;
  endtask

  task automatic test_reset_mid();
    bit got;
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (data_ready && ((k / DIV) % 8) < 4) got = 1;
    end
    data = 32'h9876_5432; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (((k / DIV) % 8) == 5 && m_full) got = 1;
      else @(negedge clk);
    end
    checks++;
    if (!got || data_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_setup: idx5 reached=%0d data_ready=%b want 1 0", got, data_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, digit_code, an_n, code_n} !== {8'hff, 4'hf, 8'hff, 4'hf}) begin
      fails++; $display("FAIL rstmid_async: got an=%h code=%h an_n=%h code_n=%h want ff f ff f", an, digit_code, an_n, code_n);
    end
    checks++;
    if ({data_ready, load_ack} !== 2'b10) begin
      fails++; $display("FAIL rstmid_flags: got rdy=%b ack=%b want 1 0", data_ready, load_ack);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, digit_code, data_ready} !== {8'hfe, 4'ha, 1'b1}) begin
      fails++; $display("FAIL rstmid_restart: got an=%h code=%h rdy=%b want fe a 1", an, digit_code, data_ready);
    end
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      checks++;
      if (load_ack !== 1'b0 || ack_n !== 1'b0) begin
        fails++; $display("FAIL rstmid_lost_ack: got ack=%b ack_n=%b want 0 0", load_ack, ack_n);
      end
      checks++;
      if ({an, digit_code, data_ready} !== {m_an, m_code, ~m_full}) begin
        fails++; $display("FAIL rstmid_model: got %h %h %b want %h %h %b", an, digit_code, data_ready, m_an, m_code, ~m_full);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; data = 32'd0; data_valid = 1'b0; en_mask = 8'hff;
    test_reset();
    test_load_1234();
    test_zero();
    test_mask();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
